serial_rx_deserializer: RTL and testbench

Framed serial receiver: the receiving end of the 4-bit shift register's serial output (s_out).
- Detects a start bit on the serial line, then shifts in WIDTH data bits in the bit order selected by dir.
- Optionally checks a parity bit, then checks the stop bit.
- Presents the recovered word in parallel with a one-cycle valid strobe and error flags.
- Shares the bit-rate enable (enb) and direction convention of the shift register.

---
 rtl/serial_rx_deserializer.sv | 147 ++++++++++++++
 tb/tb_serial_rx_deserializer.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_rx_deserializer.sv
// serial_rx_deserializer
// Framed serial receiver for the shift register's serial output.
// A frame is one start bit (0), WIDTH data bits, an optional parity bit and
// one stop bit (1). The line is sampled only on clk edges where enb is high.
// The recovered word is presented on q with one-cycle valid/par_err/frm_err
// strobes.

module serial_rx_deserializer #(
    parameter int WIDTH      = 4,
    parameter bit PARITY_EN  = 1'b1,
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enb,
    input  logic             dir,
    input  logic             s_in,
    output logic [WIDTH-1:0] q,
    output logic             valid,
    output logic             par_err,
    output logic             frm_err,
    output logic             busy
);

    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        DATA      = 3'd1,
        PARITY    = 3'd2,
        STOP      = 3'd3,
        WAIT_IDLE = 3'd4
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic               dir_r;
    logic [WIDTH-1:0]   shreg;
    logic               pbit_r;

    // Expected parity bit for a data word: even parity is plain XOR,
    // odd parity inverts it.
    function automatic logic parity_of(input logic [WIDTH-1:0] d);
        return (^d) ^ PARITY_ODD;
    endfunction

    // Shift one line sample into the word in the bit order latched at the
    // start bit; LSB-first lands the first bit at bit 0, MSB-first at the top.
    function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] cur,
                                                  input logic            msb_first,
                                                  input logic            b);
        logic [WIDTH-1:0] nxt;
        if (msb_first) begin
            nxt = {cur[WIDTH-2:0], b};
        end else begin
            nxt = {b, cur[WIDTH-1:1]};
        end
        return nxt;
    endfunction

    // Frame sequencer: start detect, bit counting, stop check and the
    // low-line lockout after a framing error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            dir_r <= 1'b0;
        end else if (enb) begin
            case (state)
                IDLE: begin
                    if (!s_in) begin
                        state <= DATA;
                        cnt   <= '0;
                        dir_r <= dir;
                    end
                end
                DATA: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST_BIT) begin
                        state <= PARITY_EN ? PARITY : STOP;
                    end
                end
                PARITY: begin
                    state <= STOP;
                end
                STOP: begin
                    state <= s_in ? IDLE : WAIT_IDLE;
                end
                WAIT_IDLE: begin
                    if (s_in) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Data shift register: collects one bit per enabled edge in DATA.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg <= '0;
        end else if (enb && state == DATA) begin
            shreg <= shift_in(shreg, dir_r, s_in);
        end
    end

    // Parity bit capture on the enabled edge following the last data bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pbit_r <= 1'b0;
        end else if (enb && state == PARITY) begin
            pbit_r <= s_in;
        end
    end

    // Output word and strobes; strobes self-clear on the next clk edge
    // whether or not enb is high, so each lasts exactly one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q       <= '0;
            valid   <= 1'b0;
            par_err <= 1'b0;
            frm_err <= 1'b0;
        end else begin
            valid   <= 1'b0;
            par_err <= 1'b0;
            frm_err <= 1'b0;
            if (enb && state == STOP) begin
                if (s_in) begin
                    q       <= shreg;
                    valid   <= 1'b1;
                    par_err <= PARITY_EN && (pbit_r != parity_of(shreg));
                end else begin
                    frm_err <= 1'b1;
                end
            end
        end
    end

    // Busy reflects any state other than IDLE, including the error lockout.
    assign busy = (state != IDLE);

endmodule

// File: tb/tb_serial_rx_deserializer.sv
// Directed bench for serial_rx_deserializer (WIDTH=4, even parity).

module tb_serial_rx_deserializer;

    logic       clk;
    logic       rst_n;
    logic       enb;
    logic       dir;
    logic       s_in;
    logic [3:0] q;
    logic       valid;
    logic       par_err;
    logic       frm_err;
    logic       busy;

    int tests_run = 0;
    int tests_failed = 0;

    serial_rx_deserializer #(
        .WIDTH      (4),
        .PARITY_EN  (1'b1),
        .PARITY_ODD (1'b0)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .enb     (enb),
        .dir     (dir),
        .s_in    (s_in),
        .q       (q),
        .valid   (valid),
        .par_err (par_err),
        .frm_err (frm_err),
        .busy    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clk and settle just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full-rate bit: line held for one enabled edge.
    task automatic bit_fast(input logic b);
        s_in = b;
        enb  = 1'b1;
        tick();
    endtask

    // Gated bit: enb high only on every third clk.
    task automatic bit_slow(input logic b);
        s_in = b;
        enb  = 1'b0;
        tick();
        tick();
        enb = 1'b1;
        tick();
        enb = 1'b0;
    endtask

    // Send start, four data bits (seq[3] first), parity and stop at full rate.
    // dir is flipped right after the start edge to show it is ignored.
    task automatic frame(input string tag, input logic d, input logic [3:0] seq,
                         input logic pbit, input logic stop);
        dir = d;
        bit_fast(1'b0);
        chk({tag, "_busy_start"}, 32'(busy), 32'd1);
        dir = ~d;
        for (int i = 3; i >= 0; i--) bit_fast(seq[i]);
        bit_fast(pbit);
        chk({tag, "_busy_prestop"}, 32'(busy), 32'd1);
        bit_fast(stop);
    endtask

    initial begin
        rst_n = 1'b0;
        enb   = 1'b1;
        dir   = 1'b0;
        s_in  = 1'b1;

        // 1. Reset held with a toggling line.
        for (int i = 0; i < 6; i++) begin
            s_in = i[0];
            tick();
        end
        chk("rst_q", 32'(q), 32'h0);
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_par_err", 32'(par_err), 32'd0);
        chk("rst_frm_err", 32'(frm_err), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        s_in  = 1'b1;
        rst_n = 1'b1;
        tick();
        tick();
        tick();
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_valid", 32'(valid), 32'd0);

        // 2. LSB-first: data 1,1,0,1 -> 1011, parity 1 (even).
        frame("lsb", 1'b0, 4'b1101, 1'b1, 1'b1);
        chk("lsb_valid", 32'(valid), 32'd1);
        chk("lsb_q", 32'(q), 32'hB);
        chk("lsb_par_err", 32'(par_err), 32'd0);
        chk("lsb_busy_end", 32'(busy), 32'd0);
        bit_fast(1'b1);
        chk("lsb_valid_clear", 32'(valid), 32'd0);

        // 3. MSB-first: data 1,0,1,1 -> 1011 despite dir flip mid-frame.
        s_in = 1'b1;
        enb  = 1'b0;
        tick();
        frame("msb", 1'b1, 4'b1011, 1'b1, 1'b1);
        chk("msb_valid", 32'(valid), 32'd1);
        chk("msb_q", 32'(q), 32'hB);
        chk("msb_par_err", 32'(par_err), 32'd0);
        bit_fast(1'b1);
        chk("msb_valid_clear", 32'(valid), 32'd0);

        // 4. Parity error: same as 2 with parity bit 0.
        frame("perr", 1'b0, 4'b1101, 1'b0, 1'b1);
        chk("perr_valid", 32'(valid), 32'd1);
        chk("perr_par_err", 32'(par_err), 32'd1);
        chk("perr_q", 32'(q), 32'hB);
        bit_fast(1'b1);
        chk("perr_clear", 32'(par_err), 32'd0);

        // 5. Framing error: data 0,1,1,0, parity 0, stop 0.
        frame("ferr", 1'b0, 4'b0110, 1'b0, 1'b0);
        chk("ferr_frm_err", 32'(frm_err), 32'd1);
        chk("ferr_valid", 32'(valid), 32'd0);
        chk("ferr_q_hold", 32'(q), 32'hB);
        chk("ferr_busy", 32'(busy), 32'd1);
        bit_fast(1'b0);
        chk("ferr_clear", 32'(frm_err), 32'd0);
        chk("ferr_busy_low_line", 32'(busy), 32'd1);
        chk("ferr_no_valid", 32'(valid), 32'd0);
        bit_fast(1'b1);
        chk("ferr_back_idle", 32'(busy), 32'd0);
        // Following good frame 0110 LSB-first: send 0,1,1,0, parity 0.
        frame("post", 1'b0, 4'b0110, 1'b0, 1'b1);
        chk("post_valid", 32'(valid), 32'd1);
        chk("post_q", 32'(q), 32'h6);
        chk("post_par_err", 32'(par_err), 32'd0);
        bit_fast(1'b1);

        // 6a. enb every third clk, same frame as 2.
        dir = 1'b0;
        bit_slow(1'b0);
        chk("slow_busy", 32'(busy), 32'd1);
        dir = 1'b1;
        bit_slow(1'b1);
        bit_slow(1'b1);
        bit_slow(1'b0);
        bit_slow(1'b1);
        bit_slow(1'b1);
        chk("slow_no_early_valid", 32'(valid), 32'd0);
        bit_slow(1'b1);
        chk("slow_valid", 32'(valid), 32'd1);
        chk("slow_q", 32'(q), 32'hB);
        tick();
        chk("slow_valid_single", 32'(valid), 32'd0);

        // 6b. Async reset mid-data-bits, between clk edges.
        dir = 1'b0;
        bit_fast(1'b0);
        bit_fast(1'b1);
        bit_fast(1'b0);
        chk("arst_busy_before", 32'(busy), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_q", 32'(q), 32'h0);
        chk("arst_valid", 32'(valid), 32'd0);
        s_in = 1'b1;
        #1;
        rst_n = 1'b1;
        tick();
        frame("arst_next", 1'b0, 4'b0110, 1'b0, 1'b1);
        chk("arst_next_valid", 32'(valid), 32'd1);
        chk("arst_next_q", 32'(q), 32'h6);
        chk("arst_next_par_err", 32'(par_err), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
